// File: rtl/safe_pkg.sv
// Shared types for the dual-core safe-mode sync arbiter.
// Holds the core indices, the FSM state type and the output bundle.
package safe_pkg;

  localparam int   NCORES = 2;
  localparam logic CORE0  = 1'b0;
  localparam logic CORE1  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SECOND,
    BOTH_PEND,
    WAIT_DONE,
    SYNCED,
    TIMEOUT
  } safe_sync_state_e;

  typedef struct packed {
    logic sync1;
    logic sync2;
    logic dual_sync;
    logic first_core;
    logic timeout;
    logic error;
  } safe_sync_out_t;

endpackage

// File: rtl/safe_edge_det.sv
// Per-bit rising-edge detector.
// Keeps a registered copy of the input; edges are qualified by en_i.
module safe_edge_det #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] d_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_q <= '0;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q & {W{en_i}};

endmodule

// File: rtl/safe_sync_arbiter.sv
// Orders two cores' sync-point arrivals into Sync1/Sync2 pulses,
// supervises the arrival window and raises Dual_Sync on restore.
module safe_sync_arbiter
  import safe_pkg::*;
#(
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 clear_i,
  input  logic [1:0]           req_i,
  input  logic [1:0]           done_i,
  input  logic [TIMEOUT_W-1:0] timeout_cycles_i,
  output logic                 sync1_o,
  output logic                 sync2_o,
  output logic                 dual_sync_o,
  output logic                 first_core_o,
  output logic                 timeout_o,
  output logic                 error_o
);

  localparam logic [TIMEOUT_W-1:0] CNT_ONE = TIMEOUT_W'(1);
  localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

  safe_sync_state_e     state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [NCORES-1:0]    arrived_q, arrived_d;
  logic [NCORES-1:0]    done_q, done_d;
  logic [NCORES-1:0]    rise, other;
  logic                 expire;
  safe_sync_out_t       out_q, out_d;

  safe_edge_det #(
    .W (NCORES)
  ) u_req_edge (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (en_i),
    .d_i    (req_i),
    .rise_o (rise)
  );

  assign other  = rise & ~arrived_q;
  assign expire = (timeout_cycles_i != '0) &&
                  (cnt_q == timeout_cycles_i - CNT_ONE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      arrived_q <= '0;
      done_q    <= '0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      arrived_q <= arrived_d;
      done_q    <= done_d;
      out_q     <= out_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    arrived_d        = arrived_q;
    done_d           = done_q;
    out_d            = '0;
    out_d.dual_sync  = out_q.dual_sync;
    out_d.first_core = out_q.first_core;
    out_d.error      = out_q.error;

    if (clear_i || !en_i) begin
      state_d          = IDLE;
      cnt_d            = '0;
      arrived_d        = '0;
      done_d           = '0;
      out_d.dual_sync  = 1'b0;
      out_d.first_core = 1'b0;
      if (clear_i) begin
        out_d.error = 1'b0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise == 2'b11) begin
            state_d          = BOTH_PEND;
            arrived_d        = 2'b11;
            out_d.sync1      = 1'b1;
            out_d.first_core = CORE0;
          end else if (rise != 2'b00) begin
            state_d          = WAIT_SECOND;
            arrived_d        = rise;
            cnt_d            = '0;
            out_d.sync1      = 1'b1;
            out_d.first_core = rise[0] ? CORE0 : CORE1;
          end
        end
        BOTH_PEND: begin
          state_d     = WAIT_DONE;
          out_d.sync2 = 1'b1;
        end
        WAIT_SECOND: begin
          // A late arrival in the expiry cycle still counts.
          if (other != '0) begin
            state_d     = WAIT_DONE;
            arrived_d   = 2'b11;
            out_d.sync2 = 1'b1;
          end else if (expire) begin
            state_d       = TIMEOUT;
            out_d.timeout = 1'b1;
            out_d.error   = 1'b1;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        WAIT_DONE: begin
          done_d = done_q | done_i;
          if (done_d == 2'b11) begin
            state_d         = SYNCED;
            out_d.dual_sync = 1'b1;
          end
          if (rise != '0) begin
            out_d.error = 1'b1;
          end
        end
        SYNCED: begin
          state_d = SYNCED;
        end
        TIMEOUT: begin
          state_d = TIMEOUT;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign sync1_o      = out_q.sync1;
  assign sync2_o      = out_q.sync2;
  assign dual_sync_o  = out_q.dual_sync;
  assign first_core_o = out_q.first_core;
  assign timeout_o    = out_q.timeout;
  assign error_o      = out_q.error;

endmodule
